// File: rtl/char_scanout.sv
// char_scanout: raster scan of the character buffer into a 1-bit pixel stream.
// Buffer read -> font ROM -> shifter, with a block-cursor overlay.
module char_scanout #(
  parameter int COLS      = 80,
  parameter int ROWS      = 24,
  parameter int CHAR_W    = 8,
  parameter int CHAR_H    = 16,
  parameter int ADDR_BITS = 11,
  parameter int CROW_BITS = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   frame_start,
  input  logic                   line_start,
  output logic [ADDR_BITS-1:0]   raddr,
  input  logic [7:0]             char_in,
  output logic [8+CROW_BITS-1:0] font_addr,
  input  logic [CHAR_W-1:0]      font_data,
  input  logic [ADDR_BITS-1:0]   cursor_addr,
  input  logic                   cursor_on,
  output logic                   pixel,
  output logic                   pixel_valid
);

  localparam int RB = $clog2(ROWS + 1);
  localparam int CB = $clog2(COLS);
  localparam int PB = $clog2(CHAR_W);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t                 state, state_n;
  logic [RB-1:0]          row, row_nx;
  logic [CROW_BITS-1:0]   cell_row, crow_nx;
  logic [ADDR_BITS-1:0]   row_base, base_nx;
  logic [CB-1:0]          col;
  logic [PB-1:0]          phase;
  logic [1:0]             dcnt;
  logic                   line_end, start, flush, last_beat;
  logic                   ld1, ld2, v1, v2, c1, c2;
  logic [CHAR_W-1:0]      shifter;

  assign font_addr = {char_in, cell_row};
  assign pixel     = shifter[CHAR_W-1];
  assign last_beat = (phase == PB'(CHAR_W - 1)) &&
                     (col == CB'(COLS - 1));
  assign line_end  = (state == DRAIN) && (dcnt == 2'd2);

  // Line/row counters as they stand after this edge; a line_start in the
  // final drain cycle sees the completed line already counted.
  always_comb begin
    row_nx  = row;
    crow_nx = cell_row;
    base_nx = row_base;
    if (frame_start) begin
      row_nx  = '0;
      crow_nx = '0;
      base_nx = '0;
    end else if (line_end) begin
      crow_nx = cell_row + 1'b1;
      if (cell_row == CROW_BITS'(CHAR_H - 1)) begin
        row_nx  = row + 1'b1;
        base_nx = row_base + ADDR_BITS'(COLS);
      end
    end
    start = line_start && (row_nx < RB'(ROWS));
    flush = frame_start || start;
  end

  // Next-state logic; frame_start idles, an accepted line_start (re)fetches.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = IDLE;
      FETCH:   if (last_beat) state_n = DRAIN;
      DRAIN:   if (dcnt == 2'd2) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (frame_start) state_n = IDLE;
    if (start) state_n = FETCH;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  // Scan counters and buffer read address.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      row      <= '0;
      cell_row <= '0;
      row_base <= '0;
      col      <= '0;
      phase    <= '0;
      dcnt     <= '0;
      raddr    <= '0;
    end else begin
      row      <= row_nx;
      cell_row <= crow_nx;
      row_base <= base_nx;
      dcnt     <= (state == DRAIN && state_n == DRAIN) ?
                  dcnt + 2'd1 : 2'd0;
      if (start) begin
        col   <= '0;
        phase <= '0;
        raddr <= base_nx;
      end else if (state == FETCH) begin
        phase <= phase + 1'b1;
        if (phase == PB'(CHAR_W - 1)) begin
          phase <= '0;
          if (col != CB'(COLS - 1)) begin
            col   <= col + 1'b1;
            raddr <= raddr + 1'b1;
          end
        end
      end
    end
  end

  // Pixel pipeline: load/valid/cursor tags ride along with buffer and ROM
  // latency, then the shifter serialises MSB first.
  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      ld1         <= 1'b0;
      ld2         <= 1'b0;
      v1          <= 1'b0;
      v2          <= 1'b0;
      c1          <= 1'b0;
      c2          <= 1'b0;
      pixel_valid <= 1'b0;
      shifter     <= '0;
    end else begin
      ld1         <= (state == FETCH) && (phase == '0);
      ld2         <= ld1;
      v1          <= (state == FETCH);
      v2          <= v1;
      pixel_valid <= v2;
      c1          <= (raddr == cursor_addr) && cursor_on;
      c2          <= c1;
      if (ld2) shifter <= font_data ^ {CHAR_W{c2}};
      else     shifter <= {shifter[CHAR_W-2:0], 1'b0};
    end
  end

endmodule

// File: tb/tb_char_scanout.sv
// tb_char_scanout: random line/frame/cursor stimulus against a timeline model
// of the scan (line start time, row, cell row) plus literal spot checks.
module tb_char_scanout;

  localparam int COLS  = 80;
  localparam int ROWS  = 2;
  localparam int CW    = 8;
  localparam int CH    = 16;
  localparam int LINE  = COLS * CW;
  localparam int FULL  = LINE + 3;

  logic        clk = 1'b0;
  logic        reset_n, frame_start, line_start;
  logic [10:0] raddr;
  logic [7:0]  char_in = '0;
  logic [11:0] font_addr;
  logic [7:0]  font_data = '0;
  logic [10:0] cursor_addr;
  logic        cursor_on;
  logic        pixel, pixel_valid;

  logic [7:0]  mem [0:2047];
  logic [7:0]  font_mem [0:4095];
  bit          font_zero;
  bit          run;

  int vectors;
  int miscompares;

  char_scanout #(
    .COLS(COLS), .ROWS(ROWS), .CHAR_W(CW), .CHAR_H(CH),
    .ADDR_BITS(11), .CROW_BITS(4)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .frame_start(frame_start), .line_start(line_start),
    .raddr(raddr), .char_in(char_in),
    .font_addr(font_addr), .font_data(font_data),
    .cursor_addr(cursor_addr), .cursor_on(cursor_on),
    .pixel(pixel), .pixel_valid(pixel_valid)
  );

  always #5 clk = ~clk;

  // Buffer RAM and font ROM, both one-cycle registered reads.
  always @(posedge clk) begin
    char_in   <= mem[raddr];
    font_data <= font_zero ? 8'h00 : font_mem[font_addr];
  end

  // Timeline model: what line is running, since which edge, on which row.
  int  n, s, base, crs, mrow, mcrow;
  bit  started, active, con;
  logic [10:0] cadr;

  always @(posedge clk) begin
    if (!reset_n) begin
      n = 0; s = 0; base = 0; crs = 0;
      mrow = 0; mcrow = 0;
      started = 0; active = 0;
    end else begin
      n++;
      if (active && (n - s) == FULL) begin
        active = 0;
        mcrow++;
        if (mcrow == CH) begin
          mcrow = 0;
          mrow++;
        end
      end
      if (frame_start) begin
        mrow = 0; mcrow = 0; active = 0;
      end
      if (line_start && mrow < ROWS) begin
        s = n; started = 1; active = 1;
        base = mrow * COLS; crs = mcrow;
        cadr = cursor_addr; con = cursor_on;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h at t=%0t",
               name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  int k, j, a, col;
  logic [7:0] fb;
  logic [10:0] er;
  logic epv, epx;
  always @(negedge clk) begin
    if (run) begin
      k = n - s;
      er = '0;
      if (started) begin
        col = k / CW;
        if (col > COLS - 1) col = COLS - 1;
        er = 11'(base + col);
      end
      epv = started && k >= 3 && k <= LINE + 2;
      epx = 1'b0;
      if (epv) begin
        j = k - 3;
        a = base + j / CW;
        fb = font_zero ? 8'h00 : font_mem[{mem[a], 4'(crs)}];
        epx = fb[CW - 1 - (j % CW)] ^ (con && 11'(a) == cadr);
      end
      chk("raddr", 32'(raddr), 32'(er));
      chk("pixel_valid", 32'(pixel_valid), 32'(epv));
      chk("pixel", 32'(pixel), 32'(epx));
      chk("font_addr", 32'(font_addr), 32'({char_in, 4'(mcrow)}));
    end
  end

  task automatic wait_cyc(input int c);
    repeat (c) @(negedge clk);
  endtask

  // Pulse line_start; returns at the negedge after the sampling edge E0.
  task automatic start_line();
    @(negedge clk) line_start = 1'b1;
    @(negedge clk) line_start = 1'b0;
  endtask

  task automatic frame();
    @(negedge clk) frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
  endtask

  task automatic full_line(input int extra);
    start_line();
    wait_cyc(LINE + 1 + extra);
  endtask

  logic [7:0] pat;
  int pvcnt, r;

  initial begin
    vectors = 0; miscompares = 0; run = 0;
    reset_n = 1'b0; frame_start = 1'b0; line_start = 1'b0;
    cursor_addr = '0; cursor_on = 1'b0; font_zero = 0;
    for (int i = 0; i < 2048; i++) mem[i] = 8'h41;
    for (int i = 0; i < 4096; i++) font_mem[i] = 8'($urandom);
    font_mem[12'h410] = 8'h18;

    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run = 1;
    chk("rst_raddr", 32'(raddr), 0);
    chk("rst_pixel", 32'(pixel), 0);
    chk("rst_pv", 32'(pixel_valid), 0);
    wait_cyc(5);
    chk("idle_pv", 32'(pixel_valid), 0);

    // Line 0 of 'A' row 0 = 0x18.
    frame();
    start_line();
    chk("l0_raddr0", 32'(raddr), 0);
    pat = 8'h18;
    pvcnt = 32'(pixel_valid);
    for (int i = 1; i <= 650; i++) begin
      @(negedge clk);
      if (i >= 3 && i <= 10)
        chk("l0_px", 32'(pixel), 32'(pat[CW - 1 - (i - 3)]));
      if (i == 8) chk("l0_raddr1", 32'(raddr), 1);
      pvcnt += 32'(pixel_valid);
    end
    chk("l0_pvcnt", pvcnt, LINE);

    for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);

    // Lines 1..15, including exact minimum spacing.
    for (int l = 1; l <= 15; l++) begin
      start_line();
      wait_cyc(5);
      if (l == 4) begin
        chk("l4_crow", 32'(font_addr[3:0]), 4);
        chk("l4_char", 32'(font_addr[11:4]), 32'(char_in));
      end
      wait_cyc((l == 2) ? 636 : $urandom_range(636, 650));
    end

    // Line 16: second text row.
    start_line();
    chk("l16_raddr", 32'(raddr), 80);
    chk("l16_crow", 32'(font_addr[3:0]), 0);
    wait_cyc(639);
    chk("l16_rlast", 32'(raddr), 159);
    wait_cyc(6);

    // Line 17: cursor on cell 82 over a blank font.
    font_zero = 1; cursor_addr = 11'd82; cursor_on = 1'b1;
    start_line();
    for (int i = 1; i <= 650; i++) begin
      @(negedge clk);
      chk("cur_px", 32'(pixel), 32'(i >= 19 && i <= 26));
    end

    // Line 18: cursor disabled.
    cursor_on = 1'b0;
    start_line();
    pvcnt = 0;
    for (int i = 1; i <= 650; i++) begin
      @(negedge clk);
      pvcnt += 32'(pixel);
    end
    chk("nocur_px", pvcnt, 0);
    font_zero = 0;

    for (int l = 19; l <= 31; l++) begin
      cursor_addr = 11'($urandom_range(80, 159));
      cursor_on = 1'($urandom);
      full_line($urandom_range(0, 12));
    end

    // Past the last text row: ignored.
    start_line();
    pvcnt = 0;
    for (int i = 1; i <= 700; i++) begin
      @(negedge clk);
      pvcnt += 32'(pixel_valid);
    end
    chk("past_end_pv", pvcnt, 0);
    chk("past_end_raddr", 32'(raddr), 159);

    // Abort mid-line.
    frame();
    for (int l = 0; l < 3; l++) full_line(3);
    start_line();
    wait_cyc(199);
    start_line();
    chk("abort_pv", 32'(pixel_valid), 0);
    chk("abort_raddr", 32'(raddr), 0);
    chk("abort_crow", 32'(font_addr[3:0]), 3);
    wait_cyc(LINE + 10);
    start_line();
    chk("after_abort_crow", 32'(font_addr[3:0]), 4);
    wait_cyc(100);
    @(negedge clk) begin frame_start = 1'b1; line_start = 1'b1; end
    @(negedge clk) begin frame_start = 1'b0; line_start = 1'b0; end
    chk("fsls_raddr", 32'(raddr), 0);
    chk("fsls_crow", 32'(font_addr[3:0]), 0);
    wait_cyc(LINE + 10);

    // Random mix of full lines, aborts and frame restarts.
    for (int it = 0; it < 40; it++) begin
      cursor_addr = 11'($urandom_range(0, 159));
      cursor_on = 1'($urandom);
      r = $urandom_range(0, 9);
      if (r == 0) begin
        start_line();
        wait_cyc($urandom_range(1, 640));
        full_line(2);
      end else if (r == 1) begin
        @(negedge clk) begin frame_start = 1'b1; line_start = 1'b1; end
        @(negedge clk) begin frame_start = 1'b0; line_start = 1'b0; end
        wait_cyc(LINE + 3);
      end else if (r == 2) begin
        frame();
      end else begin
        full_line($urandom_range(0, 8));
      end
    end

    wait_cyc(5);
    run = 0;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/char_scanout.md
# char_scanout

Read-side scan engine for the 80x24 character buffer RAM. Walks buffer addresses in raster order for each active scanline, forms font ROM addresses from the returned character codes and the current cell row, and serialises font bits into a one-bit pixel stream with a block-cursor overlay. Sits between the video timing generator and the pixel output path, and drives the buffer's read port (`raddr`/`dout`, registered read, 1-cycle latency) plus an external synchronous font ROM (1-cycle latency).

## Interface
- `COLS`, 80, characters per row
- `ROWS`, 24, character rows
- `CHAR_W`, 8, pixels per cell (font row width)
- `CHAR_H`, 16, scanlines per cell (power of 2)
- `ADDR_BITS`, 11, buffer address width
- `CROW_BITS`, 4, log2(`CHAR_H`)

- `clk` in 1: single clock, one pixel per cycle
- `reset_n` in 1: synchronous, active-low reset
- `frame_start` in 1: one-cycle pulse, start of frame
- `line_start` in 1: one-cycle pulse, start of a scanline's fetch window
- `raddr` out `ADDR_BITS`: buffer read address (registered)
- `char_in` in 8: buffer read data, valid the cycle after `raddr`
- `font_addr` out 8+`CROW_BITS`: `{char_in, cell_row}`, combinational from `char_in`
- `font_data` in `CHAR_W`: font ROM data, valid the cycle after `font_addr`; MSB is leftmost pixel
- `cursor_addr` in `ADDR_BITS`: cursor cell address
- `cursor_on` in 1: cursor enabled and in visible blink phase
- `pixel` out 1: pixel value (registered)
- `pixel_valid` out 1: high during the `COLS*CHAR_W` active pixels of a line (registered)

## Operation
- Counters: `row` (0..`ROWS`), `cell_row` (0..`CHAR_H`-1), `row_base` (=`row*COLS`, maintained by adding `COLS`; no multiplier), `col` (0..`COLS`-1), `phase` (0..`CHAR_W`-1).
- States: IDLE, FETCH, DRAIN.
  - IDLE: on `line_start` with `row < ROWS` -> FETCH, `col=0`, `phase=0`, `raddr<=row_base`. If `row == ROWS` (past last text line), `line_start` is ignored and outputs stay 0.
  - FETCH: `phase` counts each cycle. At `phase==CHAR_W-1`, `col++` and `raddr++`. After the last column's final phase -> DRAIN.
  - DRAIN: 3 cycles while the pixel pipeline empties -> IDLE. On entering IDLE, the line is complete: `cell_row++`. On wrap from `CHAR_H-1` to 0, `row++` and `row_base += COLS`.
- Load pulse: `phase==0` in FETCH, delayed 3 cycles. It loads the shifter with `font_data` (inverted if the cursor flag is set). Otherwise the shifter shifts left one bit per cycle. `pixel` is the shifter MSB.
- Cursor flag: `(raddr == cursor_addr) & cursor_on`, sampled with `raddr` and carried 3 stages alongside the data.
- `frame_start`: `row=0`, `cell_row=0`, `row_base=0`, state to IDLE, pipeline flushed. It takes priority over a simultaneous `line_start`, and that `line_start` is then honoured as line 0.
- `line_start` while in FETCH or DRAIN aborts the line: pipeline flushed, line not counted (`cell_row` unchanged), fetch restarts at `row_base`.
- Reset: `raddr=0`, `pixel=0`, `pixel_valid=0`, all counters 0, state IDLE, shifter 0.

## Timing
- E0 = edge sampling `line_start`=1. Sequence: after E0, `raddr=row_base`. After E1, `char_in`/`font_addr` are valid. After E2, `font_data` is valid. After E3, the first pixel (bit `CHAR_W-1` of column 0) is on `pixel` with `pixel_valid`=1.
- `pixel_valid` is high for exactly `COLS*CHAR_W` (640) consecutive cycles, from after E3 through after E642.
- `raddr` holds each address for `CHAR_W` cycles. The last address is `row_base+COLS-1`, and `raddr` holds it until the next line start.
- Minimum `line_start` spacing for full lines is `COLS*CHAR_W+3` cycles; shorter spacing triggers the abort rule above.

## Test plan
- Reset with `reset_n`=0 for 2 cycles, then release -> `raddr`=0, `pixel`=0, `pixel_valid`=0; no activity until `line_start`.
- `frame_start`, then `line_start` at E0; buffer all 0x41, font row 0 of 'A' = 0x18 -> `raddr` 0 after E0, 1 after E8; pixels 0,0,0,1,1,0,0,0 starting after E3; `pixel_valid` high 640 cycles.
- Drive 16 complete lines after `frame_start` -> line 17 fetches `raddr` 80..159 with `cell_row`=0. `font_addr` on line 5 = `{char,4'd4}`.
- `cursor_addr`=82, `cursor_on`=1, row 1, font byte 0x00 -> pixels after E19..E26 of that line are 1, all others 0. With `cursor_on`=0 -> all 0.
- 384 lines (`ROWS*CHAR_H`) then another `line_start` -> ignored; `pixel_valid` stays 0 until `frame_start`.
- `line_start` at 200 cycles into a line -> `pixel_valid` drops, refetch from same `row_base`, same `cell_row`. Also `frame_start`+`line_start` in the same cycle -> line 0 starts at `raddr`=0.
